// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: owns the fetch PC, issues credit-limited word reads to imem and
// buffers returned words with their PC in a DEPTH-entry FIFO; redirect flushes and
// discards stale in-flight responses.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc, resp_pc;
    logic [31:0]   fifo_word [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, inflight, discard;
    logic [CW:0]   credit;
    logic          issue, resp, push, pop;

    assign imem_addr  = fetch_pc[31:2];
    assign inst_valid = count != '0;
    assign inst       = inst_valid ? fifo_word[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr] : '0;

    // Request credit and per-cycle event decode; redirect masks everything but the flush
    always_comb begin
        credit   = {1'b0, count} + {1'b0, inflight};
        imem_req = reset && !redirect && (credit < (CW+1)'(DEPTH));
        issue    = imem_req && imem_gnt;
        resp     = imem_rvalid && !redirect;
        push     = resp && (discard == '0);
        pop      = inst_valid && inst_ready && !redirect;
    end

    // Control state: PCs, FIFO pointers, occupancy and in-flight/discard credit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            resp_pc  <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= inflight - CW'(imem_rvalid);
            discard  <= inflight - CW'(imem_rvalid);
        end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                wr_ptr  <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (resp && discard != '0) discard <= discard - CW'(1);
            inflight <= inflight + CW'(issue) - CW'(resp);
            count    <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are masked at the outputs while empty so no reset is needed
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_word[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end
endmodule
